// File: rtl/p2s_pkg.sv
// p2s_pkg: shared definitions for the parallel-to-serial scheduler.
//   - FSM state encoding used by p2s_scheduler
//   - default N / WIDTH / GAP values
//   - rr_next: round-robin winner search over a request vector
package p2s_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_GAP   = 1;

  // Widest request vector rr_next can search (largest supported N).
  localparam int MAX_N     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Returns the first set bit of req (among the low n bits), searching
  // upward from (last+1) mod n and wrapping. Returns 0 when nothing is set;
  // callers only use the result when at least one request is present.
  function automatic logic [2:0] rr_next(input logic [MAX_N-1:0] req,
                                         input logic [2:0]       last,
                                         input int unsigned      n);
    logic [2:0] win;
    logic [2:0] idx;
    logic       found;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_N; i++) begin
      idx = 3'((32'(last) + i) % n);
      if (!found && (i <= n) && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/p2s_shifter.sv
// p2s_shifter: WIDTH-bit load/shift register with bit counter.
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   load         in   capture word and present bit 0 next cycle
//   shift        in   advance to the next bit (ignored when idle)
//   word         in   WIDTH-bit word to serialize, LSB first
//   d            out  current serial bit, 0 when no frame is active
//   serial_start out  high while bit 0 is on d
//   serial_end   out  high while bit WIDTH-1 is on d
//   counter      out  index of the bit on d, 0 outside frames
module p2s_shifter
  import p2s_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] word,
  output logic             d,
  output logic             serial_start,
  output logic             serial_end,
  output logic [CW-1:0]    counter
);

  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_act;
  logic             w_last;

  assign w_last = r_act && (r_cnt == CW'(WIDTH - 1));

  // Control: frame-active flag and bit index. Load wins over shift so a
  // back-to-back frame can start on the edge that retires the last bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_act <= 1'b0;
      r_cnt <= '0;
    end else if (load) begin
      r_act <= 1'b1;
      r_cnt <= '0;
    end else if (shift && r_act) begin
      if (w_last) begin
        r_act <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Data: the shift register itself needs no reset; d is gated by r_act.
  always_ff @(posedge clk) begin
    if (load) begin
      r_sr <= word;
    end else if (shift && r_act) begin
      r_sr <= r_sr >> 1;
    end
  end

  assign d            = r_act & r_sr[0];
  assign serial_start = r_act && (r_cnt == '0);
  assign serial_end   = w_last;
  assign counter      = r_cnt;

endmodule

// File: rtl/p2s_scheduler.sv
// p2s_scheduler: round-robin arbiter sharing one parallel-to-serial shifter
// among N requesters. Each grant captures the winner's word, pulses its ack
// and sends the word LSB-first framed by serial_start / serial_end, followed
// by GAP idle cycles.
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   req[N]       in   request levels, held until ack
//   data[N*W]    in   requester k word at [k*WIDTH +: WIDTH]
//   ack[N]       out  one-cycle pulse, coincident with serial_start
//   grant_id     out  index of the requester currently being served
//   busy         out  high from bit 0 through the last gap cycle
//   d            out  serial data, 0 outside frames
//   serial_start out  high during bit 0
//   serial_end   out  high during bit WIDTH-1
//   counter      out  bit index on d, 0 outside frames
module p2s_scheduler
  import p2s_pkg::*;
#(
  parameter  int N     = DEF_N,
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int GAP   = DEF_GAP,
  localparam int CW    = $clog2(WIDTH),
  localparam int GW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] data,
  output logic [N-1:0]       ack,
  output logic [GW-1:0]      grant_id,
  output logic               busy,
  output logic               d,
  output logic               serial_start,
  output logic               serial_end,
  output logic [CW-1:0]      counter
);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_gap;
  logic [GW-1:0]    r_last;
  logic [GW-1:0]    r_gid;
  logic [N-1:0]     r_ack;
  logic             r_busy;

  logic [MAX_N-1:0] w_req8;
  logic [GW-1:0]    w_win;
  logic [WIDTH-1:0] w_word;
  logic [N-1:0]     w_ack_nxt;
  logic             w_any;
  logic             w_grant;
  logic             w_shift;
  logic             w_last_bit;
  logic             w_gap_done;

  always_comb begin
    w_req8        = '0;
    w_req8[N-1:0] = req;
  end

  assign w_any      = |req;
  assign w_win      = GW'(rr_next(w_req8, 3'(r_last), N));
  assign w_word     = data[w_win*WIDTH +: WIDTH];
  // When GAP is 0 the GAP state is unreachable, so the wrapped compare
  // value is never used.
  assign w_gap_done = (r_gap == 3'(GAP - 1));

  // Next state. A grant is taken from IDLE, at the end of the gap, or
  // directly off the last bit when there is no gap.
  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant = 1'b1;
          w_next  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (w_last_bit) begin
          if (GAP > 0) begin
            w_next = ST_GAP;
          end else if (w_any) begin
            w_grant = 1'b1;
            w_next  = ST_SHIFT;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (w_gap_done) begin
          if (w_any) begin
            w_grant = 1'b1;
            w_next  = ST_SHIFT;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ack_nxt = '0;
    if (w_grant) w_ack_nxt[w_win] = 1'b1;
  end

  // Control registers. last_grant resets to N-1 so requester 0 is
  // searched first after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_last  <= GW'(N - 1);
      r_gid   <= '0;
      r_ack   <= '0;
      r_busy  <= 1'b0;
      r_gap   <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      r_ack   <= w_ack_nxt;
      if (w_grant) begin
        r_last <= w_win;
        r_gid  <= w_win;
      end
      if (r_state == ST_GAP) r_gap <= r_gap + 3'd1;
      else                   r_gap <= '0;
    end
  end

  p2s_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk          (clk),
    .reset        (reset),
    .load         (w_grant),
    .shift        (w_shift),
    .word         (w_word),
    .d            (d),
    .serial_start (serial_start),
    .serial_end   (w_last_bit),
    .counter      (counter)
  );

  assign serial_end = w_last_bit;
  assign ack        = r_ack;
  assign grant_id   = r_gid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_p2s_scheduler.sv
// tb_p2s_scheduler: directed bench for p2s_scheduler. One instance uses the
// default GAP=1, a second uses GAP=0 for back-to-back frames.
module tb_p2s_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  req, req0;
  logic [31:0] data, data0;

  logic [3:0]  ack, ack_z;
  logic [1:0]  grant_id, gid_z;
  logic        busy, busy_z;
  logic        d, d_z;
  logic        serial_start, sstart_z;
  logic        serial_end, send_z;
  logic [2:0]  counter, cnt_z;

  p2s_scheduler #(.N(N), .WIDTH(W), .GAP(1)) u_dut (
    .clk(clk), .reset(reset), .req(req), .data(data),
    .ack(ack), .grant_id(grant_id), .busy(busy), .d(d),
    .serial_start(serial_start), .serial_end(serial_end), .counter(counter)
  );

  p2s_scheduler #(.N(N), .WIDTH(W), .GAP(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .data(data0),
    .ack(ack_z), .grant_id(gid_z), .busy(busy_z), .d(d_z),
    .serial_start(sstart_z), .serial_end(send_z), .counter(cnt_z)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [3:0]  rq;
    logic [31:0] dat;
    int          exp_id;
    logic [7:0]  exp_word;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ack(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack !== 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({name, "_ack_timeout"}, 32'd0, 32'd1);
  endtask

  // Called at the negedge where ack is visible; ends at the bit WIDTH-1 negedge.
  task automatic collect_frame(input string name, input int exp_id, input logic [7:0] exp_word);
    logic [7:0] w;
    int errs;
    w = '0;
    errs = 0;
    chk({name, "_ack"}, 32'(ack), 32'(1 << exp_id));
    chk({name, "_gid"}, 32'(grant_id), 32'(exp_id));
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      w[i] = d;
      if (counter !== 3'(i)) errs++;
      if (serial_start !== (i == 0)) errs++;
      if (serial_end !== (i == W - 1)) errs++;
      if (busy !== 1'b1) errs++;
      if (i > 0 && ack !== 4'b0000) errs++;
    end
    chk({name, "_word"}, 32'(w), 32'(exp_word));
    chk({name, "_frame_ctl"}, 32'(errs), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;
    bit found;
    int t_prev;
    int id;
    int errs;
    logic [7:0] w;
    logic [7:0] exp_w;

    vecs[0] = '{4'b0001, 32'h0000_00D3, 0, 8'hD3};
    vecs[1] = '{4'b0110, 32'h003C_9600, 1, 8'h96};
    vecs[2] = '{4'b0110, 32'h003C_9600, 2, 8'h3C};
    vecs[3] = '{4'b1001, 32'hA500_007E, 3, 8'hA5};
    vecs[4] = '{4'b1001, 32'hA500_007E, 0, 8'h7E};
    vecs[5] = '{4'b1111, 32'h8040_2010, 1, 8'h20};
    vecs[6] = '{4'b1101, 32'hF00F_11EE, 2, 8'h0F};
    vecs[7] = '{4'b0011, 32'h0000_55AA, 0, 8'hAA};

    reset = 1'b0;
    req   = '0;
    req0  = '0;
    data  = '0;
    data0 = '0;
    t_prev = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({ack, grant_id, busy, d, serial_start, serial_end, counter}), 32'd0);
    chk("reset_outputs_gap0", 32'({ack_z, gid_z, busy_z, d_z, sstart_z, send_z, cnt_z}), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // GAP=0: requesters 2 and 3 alternate with no idle bit between frames.
    data0 = 32'hC35A_0000;
    req0  = 4'b1100;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_z !== 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
    chk("gap0_first_ack_seen", 32'(ok), 32'd1);
    if (ok) begin
      for (int f = 0; f < 3; f++) begin
        id    = (f % 2 == 0) ? 2 : 3;
        exp_w = (id == 2) ? 8'h5A : 8'hC3;
        chk($sformatf("gap0_f%0d_ack", f), 32'(ack_z), 32'(1 << id));
        chk($sformatf("gap0_f%0d_gid", f), 32'(gid_z), 32'(id));
        if (f == 2) req0 = '0;
        w = '0;
        errs = 0;
        for (int i = 0; i < W; i++) begin
          if (i > 0) @(negedge clk);
          w[i] = d_z;
          if (cnt_z !== 3'(i)) errs++;
          if (sstart_z !== (i == 0)) errs++;
          if (send_z !== (i == W - 1)) errs++;
        end
        chk($sformatf("gap0_f%0d_word", f), 32'(w), 32'(exp_w));
        chk($sformatf("gap0_f%0d_ctl", f), 32'(errs), 32'd0);
        @(negedge clk);
        if (f < 2) chk($sformatf("gap0_f%0d_b2b", f), 32'({sstart_z, busy_z, ack_z != 4'b0000}), 32'b111);
        else       chk("gap0_idle_after", 32'({busy_z, sstart_z, d_z}), 32'd0);
      end
    end

    // Table: single-frame transactions from IDLE, round-robin pointer evolving.
    for (int v = 0; v < 8; v++) begin
      req  = vecs[v].rq;
      data = vecs[v].dat;
      wait_ack($sformatf("vec%0d", v), ok);
      req = '0;
      if (ok) begin
        collect_frame($sformatf("vec%0d", v), vecs[v].exp_id, vecs[v].exp_word);
        @(negedge clk);
        chk($sformatf("vec%0d_gap", v), 32'({busy, d, serial_end, counter}), 32'b100000);
        @(negedge clk);
        chk($sformatf("vec%0d_busy_drop", v), 32'(busy), 32'd0);
      end
    end

    // All four requesting continuously after reset: order 0,1,2,3,0, period 9.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    data = 32'h0804_0201;
    req  = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_ack($sformatf("rr%0d", f), ok);
      if (!ok) break;
      if (f > 0) chk($sformatf("rr%0d_period", f), 32'(cyc - t_prev), 32'd9);
      t_prev = cyc;
      collect_frame($sformatf("rr%0d", f), f % 4, 8'(1 << (f % 4)));
    end
    req = '0;
    repeat (3) @(negedge clk);
    chk("rr_busy_drop", 32'(busy), 32'd0);

    // req[1] raised while serial_end is high on req[0]'s frame.
    data = 32'h0000_E13B;
    req  = 4'b0001;
    wait_ack("late", ok);
    req = '0;
    if (ok) begin
      collect_frame("late_f0", 0, 8'h3B);
      req = 4'b0010;
      @(negedge clk);
      chk("late_gap", 32'({ack, busy, d}), 32'b0000_1_0);
      @(negedge clk);
      req = '0;
      collect_frame("late_f1", 1, 8'hE1);
    end
    repeat (3) @(negedge clk);

    // req[2] pulsed for one mid-frame cycle only: must be forgotten.
    data = 32'h0099_004C;
    req  = 4'b0001;
    wait_ack("pulse", ok);
    chk("pulse_ack0", 32'(ack), 32'd1);
    req = '0;
    repeat (3) @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack !== 4'b0000) seen = 1'b1;
    end
    chk("pulse_no_ack", 32'(seen), 32'd0);
    chk("pulse_idle", 32'(busy), 32'd0);

    // Reset at counter=4 mid-frame, then requester 3 after release.
    data = 32'hB700_006D;
    req  = 4'b0001;
    wait_ack("rst", ok);
    req = '0;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (counter == 3'd4) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_reach_cnt4", 32'(found), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_async_clear", 32'({ack, grant_id, busy, d, serial_start, serial_end, counter}), 32'd0);
    @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    chk("rst_held_no_grant", 32'({ack, busy, d, counter}), 32'd0);
    reset = 1'b1;
    wait_ack("rst_after", ok);
    req = '0;
    if (ok) collect_frame("rst_after", 3, 8'hB7);
    repeat (3) @(negedge clk);
    chk("final_idle", 32'({busy, ack, d}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
